// File: rtl/mul_share_pkg.sv
// Shared types and round-robin selection for the multiplier-sharing arbiter.
// MAX_REQ bounds the requester count so the selection function has a fixed width.
package mul_share_pkg;

    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rr_pick_t;

    // First requester at or after (last+1) mod n, wrapping; only the low n request bits count.
    function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [1:0]         last,
                                         input int                 n);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= n) cand = cand - n;
            if (k <= n && !pick.valid && req[cand[1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = cand[1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search starting after the last winner.
// Produces a one-hot grant, the winner index and a valid flag.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [1:0]         last_ext;
    rr_pick_t           pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        last_ext               = '0;
        last_ext[IDX_W-1:0]    = last;
        pick                   = rr_next(req_ext, last_ext, NUM_REQ);
        valid                  = pick.valid;
        idx                    = pick.idx[IDX_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = pick.valid && (pick.idx == 2'(i));
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one val/ready sequential multiplier between NUM_REQ requesters,
// one transaction at a time, with round-robin grant and per-requester response.
//
// state | meaning
// IDLE  | arbitrate; accept one operand pair from the winner
// ISSUE | present latched operands to the multiplier
// WAIT  | wait for the product, latch it
// RESP  | return product to owner until it accepts
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int WIDTH   = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_val,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic                     mul_src_val,
    input  logic                     mul_src_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_dest_val,
    output logic                     mul_dest_ready,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     busy,
    output logic [IDX_W-1:0]         owner
);

    state_t               state, state_n;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [IDX_W-1:0]     owner_q, last_q;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_val;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (req_val),
        .last  (last_q),
        .grant (grant),
        .idx   (win_idx),
        .valid (win_val)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            if (state == IDLE && win_val) begin
                a_q     <= req_a[win_idx*WIDTH +: WIDTH];
                b_q     <= req_b[win_idx*WIDTH +: WIDTH];
                owner_q <= win_idx;
            end
            if (state == WAIT && mul_dest_val) p_q <= mul_p;
            if (state == RESP && rsp_ready[owner_q]) last_q <= owner_q;
        end
    end

    // Everything is gated by rst so outputs read zero during the reset cycle itself.
    always_comb begin
        state_n        = state;
        req_ready      = '0;
        rsp_val        = '0;
        rsp_p          = '0;
        mul_src_val    = 1'b0;
        mul_dest_ready = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    req_ready = grant;
                    if (win_val) state_n = ISSUE;
                end
                ISSUE: begin
                    mul_src_val = 1'b1;
                    if (mul_src_ready) state_n = WAIT;
                end
                WAIT: begin
                    mul_dest_ready = 1'b1;
                    if (mul_dest_val) state_n = RESP;
                end
                RESP: begin
                    rsp_val[owner_q] = 1'b1;
                    rsp_p            = p_q;
                    if (rsp_ready[owner_q]) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign mul_a = rst ? a_q : '0;
    assign mul_b = rst ? b_q : '0;
    assign owner = rst ? owner_q : '0;
    assign busy  = rst && (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a 17-cycle behavioural multiplier stub.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 16;
    localparam int IDX_W   = 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_REQ-1:0]       req_val = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*WIDTH-1:0] req_b = '0;
    logic [NUM_REQ-1:0]       rsp_val;
    logic [NUM_REQ-1:0]       rsp_ready = '0;
    logic [2*WIDTH-1:0]       rsp_p;
    logic                     mul_src_val;
    logic                     mul_src_ready = 1'b1;
    logic [WIDTH-1:0]         mul_a, mul_b;
    logic                     mul_dest_val;
    logic                     mul_dest_ready;
    logic [2*WIDTH-1:0]       mul_p;
    logic                     busy;
    logic [IDX_W-1:0]         owner;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_val        (req_val),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_val        (rsp_val),
        .rsp_ready      (rsp_ready),
        .rsp_p          (rsp_p),
        .mul_src_val    (mul_src_val),
        .mul_src_ready  (mul_src_ready),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_dest_val   (mul_dest_val),
        .mul_dest_ready (mul_dest_ready),
        .mul_p          (mul_p),
        .busy           (busy),
        .owner          (owner)
    );

    // Multiplier stub: product appears 17 cycles after the operand handshake.
    logic               stub_busy;
    int                 stub_cnt;
    logic [2*WIDTH-1:0] stub_prod;

    always @(posedge clk) begin
        if (!rst) begin
            stub_busy    <= 1'b0;
            stub_cnt     <= 0;
            mul_dest_val <= 1'b0;
            mul_p        <= '0;
        end else if (mul_dest_val) begin
            if (mul_dest_ready) mul_dest_val <= 1'b0;
        end else if (stub_busy) begin
            if (stub_cnt == 1) begin
                mul_dest_val <= 1'b1;
                mul_p        <= stub_prod;
                stub_busy    <= 1'b0;
            end
            stub_cnt <= stub_cnt - 1;
        end else if (mul_src_val && mul_src_ready) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 17;
            stub_prod <= $signed(mul_a) * $signed(mul_b);
        end
    end

    task automatic wait_rsp(input int idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (rsp_val[idx]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_val = 2'b11; req_a = {16'd1, 16'd2}; req_b = {16'd3, 16'd4};
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, req_ready, rsp_val, mul_src_val, mul_dest_ready} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {busy, req_ready, rsp_val, mul_src_val, mul_dest_ready});
        end
        n_cmp++;
        if ({owner, mul_a, mul_b, rsp_p} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: owner=%0d a=%h b=%h p=%h required all 0", owner, mul_a, mul_b, rsp_p);
        end
        req_val = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, req_ready} !== 3'b0) begin
            n_err++;
            $display("FAIL idle_no_req: busy/req_ready=%b required 000", {busy, req_ready});
        end
    endtask

    task automatic test_single();
        bit ok;
        req_a = {16'd0, 16'd3}; req_b = {16'd0, 16'd5}; req_val = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL single_ready: got %b required 01", req_ready);
        end
        @(negedge clk);
        req_val = 2'b00;
        n_cmp++;
        if ({busy, mul_src_val, req_ready} !== 4'b1100 || mul_a !== 16'd3 || mul_b !== 16'd5) begin
            n_err++;
            $display("FAIL single_issue: busy/src_val/ready=%b a=%0d b=%0d required 1100 a=3 b=5",
                     {busy, mul_src_val, req_ready}, mul_a, mul_b);
        end
        @(negedge clk);
        n_cmp++;
        if ({mul_src_val, mul_dest_ready} !== 2'b01) begin
            n_err++; $display("FAIL single_wait: src_val/dest_ready=%b required 01", {mul_src_val, mul_dest_ready});
        end
        wait_rsp(0, ok);
        n_cmp++;
        if (!ok || rsp_val !== 2'b01 || rsp_p !== 32'h0000000F) begin
            n_err++; $display("FAIL single_rsp: ok=%0d rsp_val=%b rsp_p=%h required 1 01 0000000f", ok, rsp_val, rsp_p);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        n_cmp++;
        if ({busy, rsp_val} !== 3'b0) begin
            n_err++; $display("FAIL single_done: busy/rsp_val=%b required 000", {busy, rsp_val});
        end
    endtask

    task automatic test_signed();
        bit ok;
        req_a = {16'hFFFD, 16'd0}; req_b = {16'd7, 16'd0}; req_val = 2'b10;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL signed_ready: got %b required 10", req_ready);
        end
        @(negedge clk);
        req_val = 2'b00;
        n_cmp++;
        if (owner !== 1'b1) begin
            n_err++; $display("FAIL signed_owner: got %0d required 1", owner);
        end
        wait_rsp(1, ok);
        n_cmp++;
        if (!ok || rsp_val !== 2'b10 || rsp_p !== 32'hFFFFFFEB) begin
            n_err++; $display("FAIL signed_rsp: ok=%0d rsp_val=%b rsp_p=%h required 1 10 ffffffeb", ok, rsp_val, rsp_p);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        n_cmp++;
        if (busy !== 1'b0 || owner !== 1'b1) begin
            n_err++; $display("FAIL signed_done: busy=%b owner=%0d required 0 1", busy, owner);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [1:0]  exp_oh;
        logic        exp_idx;
        logic [15:0] exp_a;
        logic [31:0] exp_p;
        req_a = {16'd6, 16'd2}; req_b = {16'd6, 16'd4}; req_val = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_idx = (t % 2 == 1);
            exp_oh  = exp_idx ? 2'b10 : 2'b01;
            exp_a   = exp_idx ? 16'd6 : 16'd2;
            exp_p   = exp_idx ? 32'd36 : 32'd8;
            #1;
            n_cmp++;
            if (req_ready !== exp_oh) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b required %b", t, req_ready, exp_oh);
            end
            @(negedge clk);
            n_cmp++;
            if (owner !== exp_idx || mul_a !== exp_a) begin
                n_err++; $display("FAIL rr_issue[%0d]: owner=%0d a=%0d required %0d %0d", t, owner, mul_a, exp_idx, exp_a);
            end
            wait_rsp(int'(exp_idx), ok);
            n_cmp++;
            if (!ok || rsp_val !== exp_oh || rsp_p !== exp_p) begin
                n_err++; $display("FAIL rr_rsp[%0d]: ok=%0d rsp_val=%b rsp_p=%0d required 1 %b %0d", t, ok, rsp_val, rsp_p, exp_oh, exp_p);
            end
            rsp_ready = exp_oh;
            @(negedge clk);
            rsp_ready = 2'b00;
        end
        req_val = 2'b00;
    endtask

    task automatic test_backpressure();
        bit ok;
        mul_src_ready = 1'b0;
        req_a = {16'd0, 16'd9}; req_b = {16'd0, 16'd9}; req_val = 2'b01;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({mul_src_val, req_ready} !== 3'b100 || mul_a !== 16'd9 || mul_b !== 16'd9) begin
                n_err++; $display("FAIL bp_issue[%0d]: src_val/ready=%b a=%0d b=%0d required 100 9 9", i, {mul_src_val, req_ready}, mul_a, mul_b);
            end
            @(negedge clk);
        end
        mul_src_ready = 1'b1;
        wait_rsp(0, ok);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (!ok || {busy, rsp_val, req_ready} !== 5'b10100 || rsp_p !== 32'h51) begin
                n_err++; $display("FAIL bp_rsp[%0d]: ok=%0d busy/rsp_val/ready=%b rsp_p=%h required 1 10100 51", i, ok, {busy, rsp_val, req_ready}, rsp_p);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        n_cmp++;
        if ({busy, req_ready} !== 3'b001) begin
            n_err++; $display("FAIL bp_done: busy/req_ready=%b required 001", {busy, req_ready});
        end
        req_val = 2'b00;
    endtask

    task automatic test_nonowner_ready();
        bit ok;
        req_a = {16'd0, 16'h0100}; req_b = {16'd0, 16'h0100}; req_val = 2'b01;
        @(negedge clk);
        req_val = 2'b00;
        wait_rsp(0, ok);
        rsp_ready = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (!ok || {busy, rsp_val} !== 3'b101 || rsp_p !== 32'h00010000) begin
                n_err++; $display("FAIL nonowner_hold[%0d]: ok=%0d busy/rsp_val=%b rsp_p=%h required 1 101 00010000", i, ok, {busy, rsp_val}, rsp_p);
            end
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL nonowner_done: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        bit seen;
        req_a = {16'd5, 16'd2}; req_b = {16'd5, 16'd3}; req_val = 2'b10;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL midrst_grant: got %b required 10", req_ready);
        end
        @(negedge clk);
        req_val = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({busy, mul_dest_ready} !== 2'b11) begin
            n_err++; $display("FAIL midrst_wait: busy/dest_ready=%b required 11", {busy, mul_dest_ready});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, mul_dest_ready, mul_src_val, owner} !== 4'b0 || {mul_a, mul_b} !== 32'd0) begin
            n_err++; $display("FAIL midrst_forced: busy/dest_ready/src_val/owner=%b a=%h b=%h required 0000 0 0", {busy, mul_dest_ready, mul_src_val, owner}, mul_a, mul_b);
        end
        @(negedge clk);
        rst = 1'b1;
        n_cmp++;
        if ({busy, mul_dest_ready, mul_src_val, rsp_val, req_ready, owner} !== 8'b0) begin
            n_err++; $display("FAIL midrst_after: outputs=%b required 00000000", {busy, mul_dest_ready, mul_src_val, rsp_val, req_ready, owner});
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_val !== 2'b00) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL midrst_no_rsp: stale response seen=%0d required 0", seen);
        end
        req_val = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL midrst_ptr: got %b required 01", req_ready);
        end
        @(negedge clk);
        req_val = 2'b00;
        wait_rsp(0, ok);
        n_cmp++;
        if (!ok || rsp_val !== 2'b01 || rsp_p !== 32'd6) begin
            n_err++; $display("FAIL midrst_rsp: ok=%0d rsp_val=%b rsp_p=%0d required 1 01 6", ok, rsp_val, rsp_p);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_round_robin();
        test_backpressure();
        test_nonowner_ready();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
